// File: rtl/insn_fetch.sv
// Instruction fetch stage: drives the synchronous ROM address, tags returned words
// with their PC and queues them in a 2-entry buffer feeding decode.
module insn_fetch #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [AW+1:2] rom_addr_o,
    input  logic [31:0]   rom_rdata_i,
    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          insn_valid_o,
    input  logic          insn_ready_i,
    output logic [31:0]   insn_o,
    output logic [31:0]   insn_pc_o
);

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] req_pc_q, req_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    entry_t      ent_q [2];
    entry_t      ent_d [2];

    logic        pop, push, issue;
    logic [2:0]  occ;
    entry_t      new_ent;

    // Low target bits are ignored; the name keeps lint quiet about them.
    logic        unused_pc_lo;
    assign unused_pc_lo = ^redirect_pc_i[1:0];

    assign pop     = (cnt_q != 2'd0) & insn_ready_i;
    assign push    = resp_valid_q & ~redirect_valid_i;
    // Entries held plus the one in flight, after this cycle's pop, must leave room.
    assign occ     = 3'(cnt_q) + 3'(resp_valid_q) - 3'(pop);
    assign issue   = (occ < 3'd2);
    assign new_ent = '{insn: rom_rdata_i, pc: resp_pc_q};

    always_comb begin
        req_pc_d     = req_pc_q;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc_q;
        cnt_d        = cnt_q;
        ent_d[0]     = ent_q[0];
        ent_d[1]     = ent_q[1];
        if (redirect_valid_i) begin
            req_pc_d = {redirect_pc_i[31:2], 2'b00};
            cnt_d    = 2'd0;
        end else begin
            if (issue) begin
                req_pc_d     = req_pc_q + 32'd4;
                resp_valid_d = 1'b1;
                resp_pc_d    = req_pc_q;
            end
            // Slot 0 is always the head; a pop shifts slot 1 down.
            case ({push, pop})
                2'b10: begin
                    ent_d[cnt_q[0]] = new_ent;
                    cnt_d           = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent_d[0] = ent_q[1];
                    cnt_d    = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent_d[0] = new_ent;
                    end else begin
                        ent_d[0] = ent_q[1];
                        ent_d[1] = new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_pc_q     <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'd0;
            cnt_q        <= 2'd0;
            ent_q[0]     <= '0;
            ent_q[1]     <= '0;
        end else begin
            req_pc_q     <= req_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            cnt_q        <= cnt_d;
            ent_q[0]     <= ent_d[0];
            ent_q[1]     <= ent_d[1];
        end
    end

    assign rom_addr_o   = req_pc_q[AW+1:2];
    assign insn_valid_o = (cnt_q != 2'd0);
    assign insn_o       = ent_q[0].insn;
    assign insn_pc_o    = ent_q[0].pc;

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: behavioural stream model checked every cycle, directed
// start-up/backpressure/redirect/wrap/reset scenarios, then randomized traffic.
module tb_insn_fetch;
    localparam int unsigned MEM_DEPTH = 256;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_rdata = 32'd0;
    logic        redir_v = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn, insn_pc;

    int n_pass = 0;
    int n_chk  = 0;

    insn_fetch #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
        .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc), .insn_valid_o(insn_valid),
        .insn_ready_i(insn_ready), .insn_o(insn), .insn_pc_o(insn_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] word_of_pc(input logic [31:0] pc);
        logic [7:0] idx;
        idx = pc[9:2];
        return rom_word(idx);
    endfunction

    function automatic logic [7:0] widx(input logic [31:0] pc);
        return pc[9:2];
    endfunction

    // Synchronous ROM: data for the address presented at an edge appears after it.
    always @(posedge clk) rom_rdata <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: expected PC of the next accepted instruction, and how many upcoming
    // edges must still show an empty buffer after reset or redirect.
    logic [31:0] exp_pc = RESET_PC;
    int          wait0 = 2;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_insn = 32'd0, hold_pc = 32'd0;
    logic        addr_chk = 1'b0;
    logic [7:0]  addr_exp = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(insn_valid), 32'd0);
            chk("rst_addr", 32'(rom_addr), 32'(widx(RESET_PC)));
            chk("rst_insn", insn, 32'd0);
            chk("rst_pc", insn_pc, 32'd0);
            exp_pc    = RESET_PC;
            wait0     = 2;
            hold_prev = 1'b0;
            addr_chk  = 1'b1;
            addr_exp  = widx(RESET_PC);
        end else begin
            chk("valid", 32'(insn_valid), 32'(wait0 == 0));
            if (wait0 > 0) wait0--;
            if (hold_prev) begin
                chk("hold_insn", insn, hold_insn);
                chk("hold_pc", insn_pc, hold_pc);
            end
            if (addr_chk) chk("start_addr", 32'(rom_addr), 32'(addr_exp));
            addr_chk = 1'b0;
            if (insn_valid && insn_ready && !redir_v) begin
                chk("acc_pc", insn_pc, exp_pc);
                chk("acc_insn", insn, word_of_pc(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            hold_prev = insn_valid && !insn_ready && !redir_v;
            hold_insn = insn;
            hold_pc   = insn_pc;
            if (redir_v) begin
                exp_pc   = {redir_pc[31:2], 2'b00};
                wait0    = 2;
                addr_chk = 1'b1;
                addr_exp = widx(redir_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after reset release: edges 0 and 1 empty, edge 2 shows RESET_PC.
    task automatic startup_check();
        @(negedge clk) chk("su_v0", 32'(insn_valid), 32'd0);
        @(negedge clk) chk("su_v1", 32'(insn_valid), 32'd0);
        @(negedge clk);
        chk("su_v2", 32'(insn_valid), 32'd1);
        chk("su_insn", insn, 32'h1000_0000);
        chk("su_pc", insn_pc, 32'h0000_0000);
    endtask

    task automatic redir(input logic [31:0] tgt, input logic rdy,
                         input logic [31:0] epc, input logic [31:0] einsn);
        logic [31:0] nxt;
        nxt = epc + 32'd4;
        step();
        redir_v = 1'b1; redir_pc = tgt; insn_ready = rdy;
        step();
        redir_v = 1'b0; insn_ready = 1'b1;
        @(negedge clk);
        chk("rd_v1", 32'(insn_valid), 32'd0);
        chk("rd_addr1", 32'(rom_addr), 32'(widx(epc)));
        @(negedge clk);
        chk("rd_v2", 32'(insn_valid), 32'd0);
        chk("rd_addr2", 32'(rom_addr), 32'(widx(nxt)));
        @(negedge clk);
        chk("rd_v3", 32'(insn_valid), 32'd1);
        chk("rd_pc", insn_pc, epc);
        chk("rd_insn", insn, einsn);
    endtask

    initial begin
        logic [31:0] stall_pc;
        insn_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        startup_check();

        repeat (5) step();

        // Backpressure for 6 cycles.
        step();
        insn_ready = 1'b0;
        @(negedge clk) stall_pc = insn_pc;
        repeat (6) step();
        @(negedge clk);
        chk("bp_valid", 32'(insn_valid), 32'd1);
        chk("bp_pc", insn_pc, stall_pc);
        step();
        insn_ready = 1'b1;
        repeat (4) step();

        // Redirect to 0x40 while full.
        insn_ready = 1'b0;
        repeat (3) step();
        redir(32'h40, 1'b0, 32'h40, rom_word(8'd16));

        // Misaligned target colliding with an accept.
        repeat (4) step();
        redir(32'h43, 1'b1, 32'h40, rom_word(8'd16));

        // ROM address wrap.
        repeat (3) step();
        redir(32'h3F8, 1'b1, 32'h3F8, rom_word(8'd254));
        chk("wr_addr3", 32'(rom_addr), 32'd0);
        @(negedge clk);
        chk("wr_pc1", insn_pc, 32'h3FC);
        chk("wr_insn1", insn, rom_word(8'd255));
        chk("wr_addr4", 32'(rom_addr), 32'd1);
        @(negedge clk);
        chk("wr_pc2", insn_pc, 32'h400);
        chk("wr_insn2", insn, rom_word(8'd0));
        @(negedge clk);
        chk("wr_pc3", insn_pc, 32'h404);
        chk("wr_insn3", insn, rom_word(8'd1));

        // Asynchronous reset while the buffer is full.
        step();
        insn_ready = 1'b0;
        repeat (4) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(insn_valid), 32'd0);
        chk("ar_addr", 32'(rom_addr), 32'(widx(RESET_PC)));
        chk("ar_insn", insn, 32'd0);
        chk("ar_pc", insn_pc, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        insn_ready = 1'b1;
        startup_check();

        // Randomized traffic.
        repeat (3000) begin
            step();
            insn_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                redir_v  = 1'b1;
                redir_pc = $urandom;
            end else begin
                redir_v = 1'b0;
            end
        end
        step();
        redir_v = 1'b0;
        insn_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
